// File: rtl/gate_vector_checker_if.sv
// rtl/gate_vector_checker_if.sv - shared A/B stimulus and six gate outputs
interface gate_vector_checker_if;
    logic A;
    logic B;
    logic Y_or;
    logic Y_not;
    logic Y_nor;
    logic Y_nand;
    logic Y_xor;
    logic Y_xnor;

    modport master (
        output A, B,
        input  Y_or, Y_not, Y_nor, Y_nand, Y_xor, Y_xnor
    );

    modport slave (
        input  A, B,
        output Y_or, Y_not, Y_nor, Y_nand, Y_xor, Y_xnor
    );
endinterface

// File: rtl/gate_vector_checker.sv
// rtl/gate_vector_checker.sv - sweeps A/B over the gate set and checks all six outputs
module gate_vector_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter int PASSES        = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    gate_vector_checker_if.master        gate,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic [7:0]                   err_count,
    output logic [1:0]                   first_fail_vec,
    output logic [5:0]                   first_fail_mask
);

    typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

    localparam int CW = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam int SW = (PASSES < 2) ? 1 : $clog2(PASSES);
    localparam logic [CW-1:0] CNT_RELOAD = CW'(SETTLE_CYCLES);
    localparam logic [SW-1:0] LAST_SWEEP = SW'(PASSES - 1);
    // With no settle time a new vector is checked on its very first cycle.
    localparam state_t VEC_ENTRY = (SETTLE_CYCLES == 0) ? CHECK : SETTLE;

    state_t          state_q, state_d;
    logic [1:0]      vec_q, vec_d;
    logic [SW-1:0]   sweep_q, sweep_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic [7:0]      err_q, err_d;
    logic [1:0]      ffv_q, ffv_d;
    logic [5:0]      ffm_q, ffm_d;
    logic            seen_q, seen_d;

    logic [5:0]      expected;
    logic [5:0]      observed;
    logic [5:0]      mask;

    // Truth table for the current vector and per-gate mismatch; unknown outputs count as wrong.
    always_comb begin
        expected = {~(vec_q[1] ^ vec_q[0]), vec_q[1] ^ vec_q[0], ~(vec_q[1] & vec_q[0]),
                    ~(vec_q[1] | vec_q[0]), ~vec_q[1], vec_q[1] | vec_q[0]};
        observed = {gate.Y_xnor, gate.Y_xor, gate.Y_nand, gate.Y_nor, gate.Y_not, gate.Y_or};
        mask     = '0;
        for (int i = 0; i < 6; i++) begin
            mask[i] = (observed[i] !== expected[i]);
        end
    end

    // Sequencer: launch, settle, check each vector, repeat sweeps, then report.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        sweep_d = sweep_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        err_d   = err_q;
        ffv_d   = ffv_q;
        ffm_d   = ffm_q;
        seen_d  = seen_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    vec_d   = 2'd0;
                    sweep_d = '0;
                    cnt_d   = CNT_RELOAD;
                    err_d   = 8'd0;
                    pass_d  = 1'b0;
                    ffv_d   = 2'd0;
                    ffm_d   = 6'd0;
                    seen_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = VEC_ENTRY;
                end
            end
            SETTLE: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (mask != 6'd0) begin
                    if (err_q != 8'hFF) begin
                        err_d = err_q + 8'd1;
                    end
                    if (!seen_q) begin
                        ffv_d  = vec_q;
                        ffm_d  = mask;
                        seen_d = 1'b1;
                    end
                end
                if (vec_q != 2'd3) begin
                    vec_d   = vec_q + 2'd1;
                    cnt_d   = CNT_RELOAD;
                    state_d = VEC_ENTRY;
                end else if (sweep_q != LAST_SWEEP) begin
                    sweep_d = sweep_q + SW'(1);
                    vec_d   = 2'd0;
                    cnt_d   = CNT_RELOAD;
                    state_d = VEC_ENTRY;
                end else begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == 8'd0);
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any run without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= 2'd0;
            sweep_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= 8'd0;
            ffv_q   <= 2'd0;
            ffm_q   <= 6'd0;
            seen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            sweep_q <= sweep_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            ffv_q   <= ffv_d;
            ffm_q   <= ffm_d;
            seen_q  <= seen_d;
        end
    end

    assign gate.A          = vec_q[1];
    assign gate.B          = vec_q[0];
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign err_count       = err_q;
    assign first_fail_vec  = ffv_q;
    assign first_fail_mask = ffm_q;

endmodule

// File: tb/tb_gate_vector_checker.sv
// tb/tb_gate_vector_checker.sv - bench for gate_vector_checker across three configurations
module tb_gate_vector_checker;

    localparam int S_T[3] = '{2, 0, 2};
    localparam int P_T[3] = '{1, 3, 70};

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_r [3];
    int         fault   [3];

    logic [1:0] ab_o   [3];
    logic       busy_o [3];
    logic       done_o [3];
    logic       pass_o [3];
    logic [7:0] err_o  [3];
    logic [1:0] ffv_o  [3];
    logic [5:0] ffm_o  [3];
    logic [5:0] y_drv  [3];

    int n_cmp = 0;
    int n_bad = 0;
    int ecnt;
    int k_edge;

    int m_t [3];
    int m_ab [3];
    int m_err [3], m_pass [3], m_ffv [3], m_ffm [3];
    int e_err [3], e_pass [3], e_ffv [3], e_ffm [3];

    gate_vector_checker_if bus0 ();
    gate_vector_checker_if bus1 ();
    gate_vector_checker_if bus2 ();

    gate_vector_checker #(.SETTLE_CYCLES(2), .PASSES(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_r[0]), .gate(bus0),
        .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]), .err_count(err_o[0]),
        .first_fail_vec(ffv_o[0]), .first_fail_mask(ffm_o[0]));
    gate_vector_checker #(.SETTLE_CYCLES(0), .PASSES(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_r[1]), .gate(bus1),
        .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]), .err_count(err_o[1]),
        .first_fail_vec(ffv_o[1]), .first_fail_mask(ffm_o[1]));
    gate_vector_checker #(.SETTLE_CYCLES(2), .PASSES(70)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start_r[2]), .gate(bus2),
        .busy(busy_o[2]), .done(done_o[2]), .pass(pass_o[2]), .err_count(err_o[2]),
        .first_fail_vec(ffv_o[2]), .first_fail_mask(ffm_o[2]));

    assign ab_o[0] = {bus0.A, bus0.B};
    assign ab_o[1] = {bus1.A, bus1.B};
    assign ab_o[2] = {bus2.A, bus2.B};

    // Gate outputs: ideal truth table with optional fault: 1=XOR stuck 0, 2=OR inverted, 3=NAND X at 00.
    function automatic logic [5:0] gate_out(input int f, input logic [1:0] v);
        logic [5:0] y;
        y = {~(v[1] ^ v[0]), v[1] ^ v[0], ~(v[1] & v[0]), ~(v[1] | v[0]), ~v[1], v[1] | v[0]};
        if (f == 1) y[4] = 1'b0;
        if (f == 2) y[0] = ~y[0];
        if (f == 3 && v == 2'd0) y[3] = 1'bx;
        return y;
    endfunction

    always_comb begin
        for (int i = 0; i < 3; i++) y_drv[i] = gate_out(fault[i], ab_o[i]);
    end

    assign bus0.Y_or = y_drv[0][0]; assign bus0.Y_not = y_drv[0][1]; assign bus0.Y_nor  = y_drv[0][2];
    assign bus0.Y_nand = y_drv[0][3]; assign bus0.Y_xor = y_drv[0][4]; assign bus0.Y_xnor = y_drv[0][5];
    assign bus1.Y_or = y_drv[1][0]; assign bus1.Y_not = y_drv[1][1]; assign bus1.Y_nor  = y_drv[1][2];
    assign bus1.Y_nand = y_drv[1][3]; assign bus1.Y_xor = y_drv[1][4]; assign bus1.Y_xnor = y_drv[1][5];
    assign bus2.Y_or = y_drv[2][0]; assign bus2.Y_not = y_drv[2][1]; assign bus2.Y_nor  = y_drv[2][2];
    assign bus2.Y_nand = y_drv[2][3]; assign bus2.Y_xor = y_drv[2][4]; assign bus2.Y_xnor = y_drv[2][5];

    always #5 clk = ~clk;

    function automatic int run_len(input int i);
        return 4 * P_T[i] * (S_T[i] + 1);
    endfunction

    // Whole-run outcome: walk every vector of every sweep against the ideal table.
    task automatic summarize(input int i, output int err, output int ok, output int fv, output int fm);
        logic [5:0] o, e;
        int m;
        bit seen;
        err = 0; fv = 0; fm = 0; seen = 0;
        for (int p = 0; p < P_T[i]; p++) begin
            for (int v = 0; v < 4; v++) begin
                o = gate_out(fault[i], 2'(v));
                e = gate_out(0, 2'(v));
                m = 0;
                for (int b = 0; b < 6; b++) if (o[b] !== e[b]) m = m | (1 << b);
                if (m != 0) begin
                    err = (err < 255) ? err + 1 : 255;
                    if (!seen) begin fv = v; fm = m; seen = 1; end
                end
            end
        end
        ok = (err == 0) ? 1 : 0;
    endtask

    task automatic chk(input string nm, input int i, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL d%0d_%s at %0t: actual=%0d required=%0d", i, nm, $time, act, exp);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ecnt <= 0;
        else        ecnt <= ecnt + 1;
    end

    // Model: run position per instance, expected A/B and the results held after each run.
    always @(posedge clk or negedge rst_n) begin : model
        int e, ok, fv, fm;
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                m_t[i] <= -1; m_ab[i] <= 0;
                m_err[i] <= 0; m_pass[i] <= 0; m_ffv[i] <= 0; m_ffm[i] <= 0;
            end else if (m_t[i] < 0) begin
                if (start_r[i]) begin
                    summarize(i, e, ok, fv, fm);
                    m_t[i] <= 0; m_ab[i] <= 0;
                    m_err[i] <= 0; m_pass[i] <= 0; m_ffv[i] <= 0; m_ffm[i] <= 0;
                    e_err[i] <= e; e_pass[i] <= ok; e_ffv[i] <= fv; e_ffm[i] <= fm;
                end
            end else if (m_t[i] == run_len(i)) begin
                m_t[i] <= -1;
            end else begin
                m_t[i] <= m_t[i] + 1;
                if (m_t[i] + 1 == run_len(i)) begin
                    m_err[i] <= e_err[i]; m_pass[i] <= e_pass[i];
                    m_ffv[i] <= e_ffv[i]; m_ffm[i] <= e_ffm[i];
                end else begin
                    m_ab[i] <= ((m_t[i] + 1) / (S_T[i] + 1)) % 4;
                end
            end
        end
    end

    // Compare every instance against the model on each falling edge outside reset.
    always @(negedge clk) begin : compare
        int t, len;
        if (rst_n) begin
            for (int i = 0; i < 3; i++) begin
                t = m_t[i];
                len = run_len(i);
                if (t < 0) begin
                    chk("busy", i, busy_o[i], 0);
                    chk("done", i, done_o[i], 0);
                    chk("ab", i, ab_o[i], m_ab[i]);
                    chk("err", i, err_o[i], m_err[i]);
                    chk("pass", i, pass_o[i], m_pass[i]);
                    chk("ffv", i, ffv_o[i], m_ffv[i]);
                    chk("ffm", i, ffm_o[i], m_ffm[i]);
                end else if (t < len) begin
                    chk("busy", i, busy_o[i], 1);
                    chk("done", i, done_o[i], 0);
                    chk("ab", i, ab_o[i], (t / (S_T[i] + 1)) % 4);
                    chk("pass_run", i, pass_o[i], 0);
                end else begin
                    chk("busy_done", i, busy_o[i], 0);
                    chk("done_pulse", i, done_o[i], 1);
                    chk("ab_done", i, ab_o[i], 3);
                    chk("err_done", i, err_o[i], m_err[i]);
                    chk("pass_done", i, pass_o[i], m_pass[i]);
                    chk("ffv_done", i, ffv_o[i], m_ffv[i]);
                    chk("ffm_done", i, ffm_o[i], m_ffm[i]);
                end
            end
        end
    end

    task automatic launch(input int i);
        @(negedge clk);
        start_r[i] = 1'b1;
        @(negedge clk);
        start_r[i] = 1'b0;
        k_edge = ecnt;
    endtask

    task automatic wait_done(input int i, input int maxc, output int lat);
        lat = -1;
        for (int c = 0; c < maxc; c++) begin
            @(negedge clk);
            if (done_o[i]) begin
                lat = ecnt - k_edge;
                break;
            end
        end
        if (lat < 0) chk("done_timeout", i, 0, 1);
    endtask

    task automatic count_dones(input int i, input int cycles, output int n);
        n = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (done_o[i]) n++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat, n, d1;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin start_r[i] = 1'b0; fault[i] = 0; end
        #2;
        chk("rst_ab", 0, ab_o[0], 0);
        chk("rst_busy", 0, busy_o[0], 0);
        chk("rst_done", 0, done_o[0], 0);
        chk("rst_pass", 0, pass_o[0], 0);
        chk("rst_err", 0, err_o[0], 0);
        chk("rst_ffv", 0, ffv_o[0], 0);
        chk("rst_ffm", 0, ffm_o[0], 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Correct gates, start sampled at edge 5, done visible after edge 17.
        while (ecnt != 3) @(negedge clk);
        launch(0);
        chk("t1_start_edge", 0, k_edge, 5);
        wait_done(0, 40, lat);
        chk("t1_done_edge", 0, ecnt, 17);
        chk("t1_pass", 0, pass_o[0], 1);
        chk("t1_err", 0, err_o[0], 0);

        // XOR stuck at 0 with default settings.
        fault[0] = 1;
        launch(0);
        wait_done(0, 40, lat);
        chk("t2_lat", 0, lat, 12);
        chk("t2_err", 0, err_o[0], 2);
        chk("t2_ffv", 0, ffv_o[0], 1);
        chk("t2_ffm", 0, ffm_o[0], 6'b010000);
        chk("t2_pass", 0, pass_o[0], 0);

        // XOR stuck at 0, three sweeps, no settle time.
        fault[1] = 1;
        launch(1);
        wait_done(1, 40, lat);
        chk("t3_lat", 1, lat, 12);
        chk("t3_err", 1, err_o[1], 6);
        chk("t3_ffv", 1, ffv_o[1], 1);

        // OR inverted over seventy sweeps: count saturates.
        fault[2] = 2;
        launch(2);
        wait_done(2, 1000, lat);
        chk("t4_lat", 2, lat, 840);
        chk("t4_err", 2, err_o[2], 255);
        chk("t4_ffv", 2, ffv_o[2], 0);
        chk("t4_ffm", 2, ffm_o[2], 6'b000001);

        // NAND driven unknown while vector 00 is applied.
        fault[0] = 3;
        launch(0);
        wait_done(0, 40, lat);
        chk("t7_ffm3", 0, ffm_o[0][3], 1);
        chk("t7_err", 0, err_o[0], 1);
        chk("t7_ffv", 0, ffv_o[0], 0);

        // A second start pulse mid-run is ignored.
        fault[0] = 0;
        launch(0);
        repeat (4) @(negedge clk);
        start_r[0] = 1'b1;
        @(negedge clk);
        start_r[0] = 1'b0;
        wait_done(0, 40, lat);
        chk("t5_lat", 0, lat, 12);
        count_dones(0, 20, n);
        chk("t5_extra_done", 0, n, 0);

        // Start held high relaunches from every IDLE cycle.
        @(negedge clk);
        start_r[0] = 1'b1;
        wait_done(0, 40, lat);
        d1 = ecnt;
        wait_done(0, 40, lat);
        chk("t8_gap", 0, ecnt - d1, 14);
        start_r[0] = 1'b0;
        count_dones(0, 20, n);
        chk("t8_stop", 0, n, 0);

        // Reset while vector 2 settles, then a clean run.
        launch(0);
        repeat (6) @(negedge clk);
        chk("t6_ab_before", 0, ab_o[0], 2);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_ab", 0, ab_o[0], 0);
        chk("t6_rst_busy", 0, busy_o[0], 0);
        chk("t6_rst_done", 0, done_o[0], 0);
        chk("t6_rst_err", 0, err_o[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        count_dones(0, 20, n);
        chk("t6_no_done", 0, n, 0);
        launch(0);
        wait_done(0, 40, lat);
        chk("t6_lat", 0, lat, 12);
        chk("t6_pass", 0, pass_o[0], 1);

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gate_vector_checker.md
# gate_vector_checker

Self-checking stimulus/response stage for the Lab2 two-input gate set (OR, NOT, NOR, NAND, XOR, XNOR). It sits directly around the gate instances. It drives their shared `A`/`B` inputs upstream, sweeping all four input combinations, then consumes the six `Y` outputs downstream and checks each against the expected truth table. It reports a pass/fail verdict, an error count and the first failing vector, so gate labs run in hardware or simulation without reading `$monitor` output by eye.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 2, idle cycles after each new `A`/`B` before sampling; 0 allowed.
- `PASSES`, default 1, full 4-vector sweeps per run; ≥1.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  run request; sampled only in IDLE.
- `A`  out  1  gate input A; equals `vec[1]`.
- `B`  out  1  gate input B; equals `vec[0]`.
- `Y_or`, `Y_not`, `Y_nor`, `Y_nand`, `Y_xor`, `Y_xnor`  in  1 each  gate outputs under test.
- `busy`  out  1  high from start acceptance until the cycle before `done`.
- `done`  out  1  one-cycle pulse at end of run.
- `pass`  out  1  1 when `err_count==0` after a run.
- `err_count`  out  8  failing vectors; saturates at 255.
- `first_fail_vec`  out  2  `{A,B}` of the first failing vector.
- `first_fail_mask`  out  6  mismatch bits of the first failing vector: [0]=OR, [1]=NOT, [2]=NOR, [3]=NAND, [4]=XOR, [5]=XNOR.

## Operation
- FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE:
  - On `start`=1: `vec`←0, `sweep`←0, settle counter←`SETTLE_CYCLES`.
  - Clear `err_count`, `pass`, `first_fail_*` and the internal first-fail flag.
  - Go to SETTLE, or go directly to CHECK if `SETTLE_CYCLES`=0.
- SETTLE: decrement the counter each cycle; on the cycle the counter is 1, go to CHECK.
- CHECK:
  - Expected values: OR=A|B, NOT=~A, NOR=~(A|B), NAND=~(A&B), XOR=A^B, XNOR=~(A^B).
  - `mask` = observed XOR expected, evaluated combinationally in this cycle.
  - If `mask`≠0: `err_count`+1 (saturating; one increment per vector, not per bit).
  - If `mask`≠0 and the first-fail flag is clear: capture `vec` and `mask`, then set the flag.
  - Then:
    - If `vec`≠3: `vec`+1 and reload the counter.
    - If `vec`==3 and `sweep`<`PASSES`-1: `sweep`+1, `vec`←0, reload the counter.
    - Otherwise go to DONE.
  - Counter reload returns to SETTLE, or stays in CHECK when `SETTLE_CYCLES`=0.
- DONE: `done`=1, `pass`←(`err_count`==0 including this run's final update), then return to IDLE.
- Results hold until the next accepted `start`.
- `start` is ignored in SETTLE, CHECK and DONE. `start` held high continuously re-launches a run on each IDLE cycle.
- `A`/`B` change only on the edge entering the first SETTLE/CHECK cycle of a vector. They hold the last vector (1,1) after a run.
- `X`/`Z` on a `Y_*` input during CHECK counts as a mismatch (use `!==`-equivalent semantics in the bench model).

## Timing
- Reset (async assert, sync-released use): state=IDLE, `A`=`B`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `first_fail_vec`=0, `first_fail_mask`=0.
- Reset mid-run aborts immediately to reset values; no `done` pulse.
- `start` sampled at edge k: `busy`=1 from k through the last CHECK.
- Each vector occupies `SETTLE_CYCLES`+1 cycles (settle plus one CHECK).
- `done` is high in the cycle after edge k+4·`PASSES`·(`SETTLE_CYCLES`+1); `busy`=0 in that cycle.
- Defaults: run length 12 cycles, `done` 13 cycles after `start`.
- Registered outputs (`pass`, `err_count`, `first_fail_*`) are valid when `done`=1.

## Test plan
- Correct gates, defaults; `start` one cycle at edge 5 -> `A,B` sequence 00,01,10,11 each held 3 cycles; `done` pulse in cycle 18; `pass`=1, `err_count`=0.
- XOR output tied 0, defaults -> `err_count`=2, `first_fail_vec`=2'b01, `first_fail_mask`=6'b010000, `pass`=0.
- XOR tied 0, `PASSES`=3, `SETTLE_CYCLES`=0 -> `err_count`=6, `done` 12 cycles after `start`, `first_fail_vec`=2'b01.
- OR output inverted, `PASSES`=70 -> 280 failures, `err_count` saturates at 255, `first_fail_vec`=00, `first_fail_mask`=6'b000001.
- `start` pulsed again mid-run -> ignored, single `done`. `rst_n` low during SETTLE of vector 2 -> all outputs at reset values, no `done`. New `start` afterwards -> clean run, `pass`=1.
- `Y_nand` driven X during one CHECK -> that vector counted, mask bit [3]=1.
